// File: rtl/rv32i_fetch_pkg.sv
// Shared definitions for the RV32I fetch stage.
// Holds the instruction width, the canonical NOP encoding, the default
// reset vector, and a helper that forces a byte address onto a word boundary.
package rv32i_fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

  localparam logic [XLEN-1:0] RV32I_RESET_VECTOR_DEFAULT = 32'h0000_0000;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_fetch_if.sv
// Instruction memory bus between fetch (master) and a synchronous
// instruction memory (slave).
//   addr        : word address, bits [1:0] always zero
//   read        : read request
//   waitrequest : memory not accepting; a read is accepted on a cycle where
//                 read & ~waitrequest
//   rdata       : read data, valid exactly one cycle after acceptance
interface rv32i_fetch_if;
  import rv32i_fetch_pkg::*;

  logic [XLEN-1:0] addr;
  logic            read;
  logic            waitrequest;
  logic [XLEN-1:0] rdata;

  modport master (output addr, output read, input waitrequest, input rdata);
  modport slave  (input addr, input read, output waitrequest, output rdata);

endinterface

// File: rtl/rv32i_fetch_skid.sv
// One-entry skid buffer holding an instruction word and its PC.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   load                : capture load_data/load_pc, mark entry valid
//   drain               : entry consumed, mark invalid
//   flush               : discard entry (highest priority)
//   load_data, load_pc  : word and PC being captured
//   valid, data, pc     : entry state
module rv32i_fetch_skid
  import rv32i_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            drain,
  input  logic            flush,
  input  logic [XLEN-1:0] load_data,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] data,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RV32I_NOP;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch stage.
// Owns the issue PC, reads words from a synchronous instruction memory and
// presents instr/pc to decode. A response returning while decode is stalled
// is parked in a one-entry skid buffer; a redirect from the ALU discards
// everything younger than the target.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   stall      : decode stall; instr/pc hold, no new issue
//   update_pc  : redirect request (branch/jump/trap), beats stall
//   new_pc     : redirect target, bits [1:0] ignored
//   imem       : instruction memory bus (master side)
//   instr      : instruction presented to decode
//   pc         : PC of the instruction decode captured on the previous
//                unstalled edge (one slot behind instr)
//
// Handshake: a read is accepted on any cycle with imem.read & ~imem.waitrequest;
// its data appears on imem.rdata the following cycle and is consumed then,
// either into the output register or, when stalled, into the skid buffer.
module rv32i_fetch
  import rv32i_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RV32I_RESET_VECTOR = RV32I_RESET_VECTOR_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             update_pc,
  input  logic [XLEN-1:0]  new_pc,
  rv32i_fetch_if.master    imem,
  output logic [XLEN-1:0]  instr,
  output logic [XLEN-1:0]  pc
);

  logic [XLEN-1:0] pc_issue;
  logic [XLEN-1:0] inflight_pc;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] redirect_pc;
  logic            inflight;
  logic            accept;
  logic            squash;
  logic            ret_valid;

  logic            skid_valid;
  logic [XLEN-1:0] skid_data;
  logic [XLEN-1:0] skid_pc;

  assign redirect_pc = word_align(new_pc);

  // No issue while stalled or while the skid is occupied, which is what
  // guarantees a returning word never finds the skid already full.
  assign imem.addr = pc_issue;
  assign imem.read = ~reset & ~stall & ~skid_valid & ~update_pc;
  assign accept    = imem.read & ~imem.waitrequest;

  // Memory latency is fixed at one cycle, so the only response a redirect can
  // overtake is the one on the bus in the redirect cycle itself.
  assign squash    = inflight & update_pc;
  assign ret_valid = inflight & ~squash;

  rv32i_fetch_skid u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (stall & ret_valid),
    .drain     (~stall & skid_valid),
    .flush     (update_pc),
    .load_data (imem.rdata),
    .load_pc   (inflight_pc),
    .valid     (skid_valid),
    .data      (skid_data),
    .pc        (skid_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_issue    <= RV32I_RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= RV32I_RESET_VECTOR;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_pc <= pc_issue;
      end
      if (update_pc) begin
        pc_issue <= redirect_pc;
      end else if (accept) begin
        pc_issue <= pc_issue + 32'd4;
      end
    end
  end

  // Output register: redirect, then skid, then returning data, else a bubble.
  // pc follows instr_pc only on unstalled edges, keeping it one slot behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= RV32I_NOP;
      instr_pc <= RV32I_RESET_VECTOR;
      pc       <= RV32I_RESET_VECTOR;
    end else begin
      if (!stall) begin
        pc <= instr_pc;
      end
      if (update_pc) begin
        instr    <= RV32I_NOP;
        instr_pc <= redirect_pc;
      end else if (!stall) begin
        if (skid_valid) begin
          instr    <= skid_data;
          instr_pc <= skid_pc;
        end else if (ret_valid) begin
          instr    <= imem.rdata;
          instr_pc <= inflight_pc;
        end else begin
          instr    <= RV32I_NOP;
          instr_pc <= pc_issue;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch. Inputs change on the falling edge; outputs
// are checked 1ns later. The memory model returns memval(addr) one cycle
// after an accepted read and a poison word otherwise.
module tb_rv32i_fetch;
  import rv32i_fetch_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            stall = 1'b0;
  logic            update_pc = 1'b0;
  logic [31:0]     new_pc = 32'h0;
  logic [31:0]     instr;
  logic [31:0]     pc;
  logic            ret_pending;

  int errors = 0;
  int checks = 0;

  rv32i_fetch_if imem_bus ();

  rv32i_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .update_pc (update_pc),
    .new_pc    (new_pc),
    .imem      (imem_bus),
    .instr     (instr),
    .pc        (pc)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [31:0] memval(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_bus.rdata <= 32'hDEAD_BEEF;
      ret_pending    <= 1'b0;
    end else begin
      ret_pending    <= imem_bus.read & ~imem_bus.waitrequest;
      imem_bus.rdata <= (imem_bus.read & ~imem_bus.waitrequest) ?
                        memval(imem_bus.addr) : 32'hDEAD_BEEF;
    end
  end

  // ---------------- checking ----------------
  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // A word must never return while the skid still holds an entry.
  always @(negedge clk) begin
    if (!reset) begin
      check32("skid_overrun", {31'b0, dut.u_skid.valid & ret_pending}, 32'h0);
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input logic wr, input logic st, input logic up, input logic [31:0] np);
    @(negedge clk);
    reset                = 1'b0;
    imem_bus.waitrequest = wr;
    stall                = st;
    update_pc            = up;
    new_pc               = np;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] addr,
                            input logic rd, input logic [31:0] ins, input logic [31:0] p);
    check32({tag, "_addr"},  imem_bus.addr, addr);
    check32({tag, "_read"},  {31'b0, imem_bus.read}, {31'b0, rd});
    check32({tag, "_instr"}, instr, ins);
    check32({tag, "_pc"},    pc, p);
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    imem_bus.waitrequest = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    expect_out("rst", 32'h0, 1'b0, NOP, 32'h0);

    // Streaming from the reset vector.
    cyc(0, 0, 0, 0); expect_out("s0", 32'h0, 1, NOP, 32'h0);
    cyc(0, 0, 0, 0); expect_out("s1", 32'h4, 1, NOP, 32'h0);
    // Waitrequest for three cycles at 0x8.
    cyc(1, 0, 0, 0); expect_out("w0", 32'h8, 1, memval(32'h0), 32'h0);
    cyc(1, 0, 0, 0); expect_out("w1", 32'h8, 1, memval(32'h4), 32'h0);
    cyc(1, 0, 0, 0); expect_out("w2", 32'h8, 1, NOP, 32'h4);
    cyc(0, 0, 0, 0); expect_out("w3", 32'h8, 1, NOP, 32'h8);
    cyc(0, 0, 0, 0); expect_out("w4", 32'hC, 1, NOP, 32'h8);
    // Stall the cycle after 0xC is accepted.
    cyc(0, 1, 0, 0); expect_out("st0", 32'h10, 0, memval(32'h8), 32'h8);
    cyc(0, 1, 0, 0); expect_out("st1", 32'h10, 0, memval(32'h8), 32'h8);
    cyc(0, 0, 0, 0); expect_out("st2", 32'h10, 0, memval(32'h8), 32'h8);
    cyc(0, 0, 0, 0); expect_out("st3", 32'h10, 1, memval(32'hC), 32'h8);
    cyc(0, 0, 0, 0); expect_out("st4", 32'h14, 1, NOP, 32'hC);
    // Redirect to 0x102 while 0x14 is in flight.
    cyc(0, 0, 1, 32'h102); expect_out("rd0", 32'h18, 0, memval(32'h10), 32'h10);
    cyc(0, 0, 0, 0); expect_out("rd1", 32'h100, 1, NOP, 32'h10);
    cyc(0, 0, 0, 0); expect_out("rd2", 32'h104, 1, NOP, 32'h100);
    cyc(0, 0, 0, 0); expect_out("rd3", 32'h108, 1, memval(32'h100), 32'h100);
    // Fill the skid under stall, then redirect while it is full.
    cyc(0, 1, 0, 0); expect_out("sr0", 32'h10C, 0, memval(32'h104), 32'h100);
    cyc(0, 1, 1, 32'h100); expect_out("sr1", 32'h10C, 0, memval(32'h104), 32'h100);
    cyc(0, 0, 0, 0); expect_out("sr2", 32'h100, 1, NOP, 32'h100);
    cyc(0, 0, 0, 0); expect_out("sr3", 32'h104, 1, NOP, 32'h100);
    cyc(0, 0, 0, 0); expect_out("sr4", 32'h108, 1, memval(32'h100), 32'h100);
    cyc(0, 0, 0, 0); expect_out("sr5", 32'h10C, 1, memval(32'h104), 32'h100);

    // Asynchronous reset mid-stream, away from any clock edge.
    @(posedge clk);
    #2 reset = 1'b1;
    #1 expect_out("mrst", 32'h0, 0, NOP, 32'h0);
    cyc(0, 0, 0, 0); expect_out("r0", 32'h0, 1, NOP, 32'h0);
    cyc(0, 0, 0, 0); expect_out("r1", 32'h4, 1, NOP, 32'h0);
    cyc(0, 0, 0, 0); expect_out("r2", 32'h8, 1, memval(32'h0), 32'h0);

    // Redirect to the top word; issue PC wraps to zero.
    cyc(0, 0, 1, 32'hFFFF_FFFF); expect_out("wr0", 32'hC, 0, memval(32'h4), 32'h0);
    cyc(0, 0, 0, 0); expect_out("wr1", 32'hFFFF_FFFC, 1, NOP, 32'h4);
    cyc(0, 0, 0, 0); expect_out("wr2", 32'h0, 1, NOP, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0); expect_out("wr3", 32'h4, 1, memval(32'hFFFF_FFFC), 32'hFFFF_FFFC);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_fetch.md
Name: rv32i_fetch

Overview:
Instruction fetch stage of the rv32_cpu pipeline, directly upstream of the RV32I decoder. Owns the program counter and issues word reads to a synchronous instruction memory. Presents instructions and their PCs to decode, honouring decode stall and ALU branch/jump redirects. Holds the response of a read still in flight when a stall arrives in a 1-entry skid buffer.

Parameters:
RV32I_RESET_VECTOR  32'h00000000  first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall  in  1  decode/pipeline stall; hold outputs
update_pc  in  1  redirect request from ALU (branch taken/jump/trap)
new_pc  in  32  redirect target; bits [1:0] ignored
imem_addr  out  32  read word address (bits [1:0] always 0)
imem_read  out  1  read request
imem_waitrequest  in  1  memory not accepting; read accepted when imem_read & ~imem_waitrequest
imem_rdata  in  32  read data, valid exactly 1 cycle after acceptance
instr  out  32  instruction to decode
pc  out  32  PC of the instruction decode captured on the previous unstalled edge

Behaviour:
- Reset (async): pc_issue=RV32I_RESET_VECTOR; instr=32'h00000013 (NOP); pc=RV32I_RESET_VECTOR; imem_read=0; in-flight flag, squash flag and skid_valid=0.
- Issue: imem_addr=pc_issue. imem_read=1 when ~reset & ~stall & ~skid_valid & ~update_pc; else 0. On acceptance: pc_issue+=4 (wraps modulo 2^32), in-flight=1, inflight_pc=pc_issue. The request may change or drop while waitrequest is high; memory samples only on the acceptance cycle.
- Return (cycle after acceptance): imem_rdata is valid and in-flight clears unless re-accepted. Returned word is paired with inflight_pc.
- Output register (instr plus internal instr_pc), updated only when ~stall, in priority order:
  - Skid entry, if skid_valid (skid_valid then clears).
  - Returning data.
  - Otherwise a NOP bubble with instr_pc=pc_issue.
- Latency: acceptance at cycle N -> instr valid at N+2. Steady state with no waitrequest and no stall is 1 instruction per cycle.
- pc register: pc<=instr_pc on the same ~stall edge that updates instr. pc therefore lags instr by one pipeline slot, matching decode's internal instruction register.
- Stall: instr, pc and instr_pc hold. Returning data is written to the skid (skid_valid=1). No new issue, so at most one entry is needed. Returning data arriving while skid_valid=1 is impossible by construction; the bench asserts this.
- Redirect (update_pc=1), priority over stall and waitrequest:
  - pc_issue<={new_pc[31:2],2'b00}.
  - skid_valid cleared; any in-flight response is squashed (dropped on return).
  - instr<=NOP, instr_pc<=target.
  - No read is issued in the redirect cycle; the first read at the target is in the next cycle.
- Consecutive update_pc cycles: last target wins.
- No instruction validity or misalignment trapping here; decode handles invalid encodings.

Decomposition:
- Shared header rv32i_defs.vh: RV32I_NOP=32'h00000013, RV32I_RESET_VECTOR default, instruction width.
- One sub-module, rv32i_fetch_skid: 1-entry data+pc skid buffer with load/drain/flush.
- Issue/PC logic and output register stay in the top.

Test Plan:
- Reset release, waitrequest=0, no stall -> imem_addr 0x0,0x4,0x8 on consecutive cycles; instr=mem[0] two cycles after first accept; pc=0x0 one cycle after that.
- waitrequest high for 3 cycles at 0x8 -> addr held 0x8, NOP bubbles on instr, no skipped or duplicated addresses.
- stall asserted the cycle after accepting 0xC -> instr/pc frozen, skid holds mem[0xC], imem_read=0. Release -> instr=mem[0xC] then mem[0x10], in order.
- update_pc=1, new_pc=0x102 with a read in flight -> in-flight data dropped, next addr 0x100, instr NOP then mem[0x100].
- update_pc during stall with skid full -> skid flushed, next fetch 0x100, no stale instruction emitted.
- reset asserted mid-stream -> outputs return immediately to reset values; fetch restarts at RV32I_RESET_VECTOR.
